// File: rtl/hazard_mc_if.sv
// hazard_mc_if: bundle between the datapath/controller and the hazard unit.
//   master : datapath side, drives stage register indices/controls, receives
//            stall/flush/forward selects and MDU status.
//   slave  : hazard unit side.
// Parameters: REG_AW register index width, PERF_W stall counter width.
interface hazard_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 16
);
  // decode stage
  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD, jumpRegD;
  // execute stage
  logic [REG_AW-1:0] rsE, rtE, writeRegE;
  logic              regWriteE, memToRegE, mduStartE;
  // memory stage
  logic [REG_AW-1:0] writeRegM;
  logic              regWriteM, memToRegM, hilo_weM, exceptM;
  // writeback stage
  logic [REG_AW-1:0] writeRegW;
  logic              regWriteW, hilo_weW;
  // hazard unit outputs
  logic              stallF, stallD, stallE;
  logic              flushD, flushE, flushM, flushW;
  logic              forwardAD, forwardBD;
  logic [1:0]        forwardAE, forwardBE, forwardHiloE;
  logic              mduBusy, mduDone;
  logic [PERF_W-1:0] stallCycles;

  modport master (
    output rsD, rtD, branchD, jumpRegD,
    output rsE, rtE, writeRegE, regWriteE, memToRegE, mduStartE,
    output writeRegM, regWriteM, memToRegM, hilo_weM, exceptM,
    output writeRegW, regWriteW, hilo_weW,
    input  stallF, stallD, stallE, flushD, flushE, flushM, flushW,
    input  forwardAD, forwardBD, forwardAE, forwardBE, forwardHiloE,
    input  mduBusy, mduDone, stallCycles
  );

  modport slave (
    input  rsD, rtD, branchD, jumpRegD,
    input  rsE, rtE, writeRegE, regWriteE, memToRegE, mduStartE,
    input  writeRegM, regWriteM, memToRegM, hilo_weM, exceptM,
    input  writeRegW, regWriteW, hilo_weW,
    output stallF, stallD, stallE, flushD, flushE, flushM, flushW,
    output forwardAD, forwardBD, forwardAE, forwardBE, forwardHiloE,
    output mduBusy, mduDone, stallCycles
  );
endinterface

// File: rtl/hazard_mc.sv
// hazard_mc: 5-stage MIPS hazard unit with multi-cycle MDU interlock.
//   clk, rst : pipeline clock, asynchronous active-high reset.
//   hz       : hazard_mc_if.slave (stage indices/controls in; stall, flush,
//              forward selects, mduBusy/mduDone, stallCycles out).
// GPR forwarding, load-use and branch-compare stalls, MDU IDLE/BUSY/DONE
// interlock, HI/LO forwarding from the MDU result, exception flush.
// Optional: define HAZARD_PERF_CNT_EN to enable the saturating stall-cycle
// counter; otherwise stallCycles is tied to zero.
module hazard_mc #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned PERF_W     = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_mc_if.slave hz
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mduState_e;

  mduState_e         stateQ, stateNext;
  logic [CNT_W-1:0]  cntQ, cntNext;
  logic              busyQ, doneQ;
  logic              mduStall, lwStall, branchStall, hazStall;

  // GPR forwarding selects, M has priority over W, r0 never forwarded
  always_comb begin
    hz.forwardAE = 2'b00;
    hz.forwardBE = 2'b00;
    if (hz.rsE != ZERO_REG && hz.rsE == hz.writeRegM && hz.regWriteM)
      hz.forwardAE = 2'b10;
    else if (hz.rsE != ZERO_REG && hz.rsE == hz.writeRegW && hz.regWriteW)
      hz.forwardAE = 2'b01;
    if (hz.rtE != ZERO_REG && hz.rtE == hz.writeRegM && hz.regWriteM)
      hz.forwardBE = 2'b10;
    else if (hz.rtE != ZERO_REG && hz.rtE == hz.writeRegW && hz.regWriteW)
      hz.forwardBE = 2'b01;
  end

  assign hz.forwardAD = (hz.rsD != ZERO_REG) && (hz.rsD == hz.writeRegM) && hz.regWriteM;
  assign hz.forwardBD = (hz.rtD != ZERO_REG) && (hz.rtD == hz.writeRegM) && hz.regWriteM;

  // HI/LO source: a just-finished MDU result beats any in-flight mthi/mtlo
  always_comb begin
    hz.forwardHiloE = 2'b00;
    if (doneQ)            hz.forwardHiloE = 2'b11;
    else if (hz.hilo_weM) hz.forwardHiloE = 2'b10;
    else if (hz.hilo_weW) hz.forwardHiloE = 2'b01;
  end

  assign lwStall     = hz.memToRegE && (hz.rsD == hz.rtE || hz.rtD == hz.rtE);
  assign branchStall = (hz.branchD || hz.jumpRegD) &&
                       ((hz.regWriteE && (hz.writeRegE == hz.rsD || hz.writeRegE == hz.rtD)) ||
                        (hz.memToRegM && (hz.writeRegM == hz.rsD || hz.writeRegM == hz.rtD)));
  assign hazStall    = lwStall || branchStall;
  // the IDLE term stalls the issuing cycle before BUSY is registered
  assign mduStall    = (stateQ == IDLE && hz.mduStartE) || (stateQ == BUSY);

  // stall/flush selects; exception overrides everything
  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    hz.flushW = 1'b0;
    if (hz.exceptM) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
      hz.flushW = 1'b1;
    end else if (mduStall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (hazStall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

  // MDU FSM next state
  always_comb begin
    stateNext = stateQ;
    cntNext   = cntQ;
    if (hz.exceptM) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      unique case (stateQ)
        IDLE: if (hz.mduStartE) begin
          stateNext = BUSY;
          cntNext   = CNT_LOAD;
        end
        BUSY: if (cntQ != '0) cntNext = cntQ - CNT_W'(1);
              else            stateNext = DONE;
        DONE: stateNext = IDLE;
        default: begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  // MDU FSM state and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateNext;
      cntQ   <= cntNext;
      busyQ  <= (stateNext == BUSY);
      doneQ  <= (stateNext == DONE);
    end
  end

  assign hz.mduBusy = busyQ;
  assign hz.mduDone = doneQ;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perfQ;

  // saturating count of fetch-stall cycles, cleared by an exception
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               perfQ <= '0;
    else if (hz.exceptM)                   perfQ <= '0;
    else if (hz.stallF && (perfQ != '1))   perfQ <= perfQ + PERF_W'(1);
  end

  assign hz.stallCycles = perfQ;
`else
  assign hz.stallCycles = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// tb_hazard_mc: directed self-checking bench for hazard_mc (MDU_CYCLES=4, PERF_W=4).
module tb_hazard_mc;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MDU_CYCLES = 4;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned PERF_W     = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PERF_SAT   = 15;
`else
  localparam int unsigned PERF_SAT   = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edges, busyCnt;

  hazard_mc_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hz();

  hazard_mc #(
    .REG_AW(REG_AW), .MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    hz.rsD = '0; hz.rtD = '0; hz.branchD = 1'b0; hz.jumpRegD = 1'b0;
    hz.rsE = '0; hz.rtE = '0; hz.writeRegE = '0;
    hz.regWriteE = 1'b0; hz.memToRegE = 1'b0; hz.mduStartE = 1'b0;
    hz.writeRegM = '0; hz.regWriteM = 1'b0; hz.memToRegM = 1'b0;
    hz.hilo_weM = 1'b0; hz.exceptM = 1'b0;
    hz.writeRegW = '0; hz.regWriteW = 1'b0; hz.hilo_weW = 1'b0;
  endtask

  // concatenation of all stall/flush outputs: {stallF,stallD,stallE,flushD,flushE,flushM,flushW}
  function automatic logic [6:0] ctl();
    return {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM, hz.flushW};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    #1;
    checkVal("rst_busy", hz.mduBusy, 0);
    checkVal("rst_done", hz.mduDone, 0);
    checkVal("rst_perf", hz.stallCycles, 0);
    checkVal("rst_ctl", ctl(), 0);
    checkVal("rst_fwd", {hz.forwardAE, hz.forwardBE, hz.forwardHiloE, hz.forwardAD, hz.forwardBD}, 0);
    @(negedge clk) rst = 1'b0;

    // GPR forwarding
    hz.regWriteW = 1'b1; hz.writeRegW = 5'd5;
    hz.regWriteM = 1'b1; hz.writeRegM = 5'd5;
    hz.rsE = 5'd5; hz.rtE = 5'd5; #1;
    checkVal("fwdAE_M", hz.forwardAE, 2'b10);
    checkVal("fwdBE_M", hz.forwardBE, 2'b10);
    hz.regWriteM = 1'b0; #1;
    checkVal("fwdAE_W", hz.forwardAE, 2'b01);
    hz.rsE = 5'd0; #1;
    checkVal("fwdAE_r0", hz.forwardAE, 2'b00);
    hz.regWriteM = 1'b1; hz.rsD = 5'd5; hz.rtD = 5'd6; #1;
    checkVal("fwdAD", {hz.forwardAD, hz.forwardBD}, 2'b10);
    hz.rsD = 5'd0; hz.writeRegM = 5'd0; #1;
    checkVal("fwdAD_r0", hz.forwardAD, 0);
    clearInputs();

    // load-use stall
    @(negedge clk);
    hz.memToRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8; hz.rtD = 5'd1; #1;
    checkVal("lw_stall", ctl(), 7'b1100100);
    hz.rsD = 5'd9; #1;
    checkVal("lw_nostall", ctl(), 7'b0000000);
    clearInputs();

    // branch-compare stalls
    hz.branchD = 1'b1; hz.rsD = 5'd3; hz.regWriteE = 1'b1; hz.writeRegE = 5'd3; #1;
    checkVal("br_stallE", ctl(), 7'b1100100);
    hz.regWriteE = 1'b0; hz.memToRegM = 1'b1; hz.writeRegM = 5'd3; #1;
    checkVal("br_stallM", ctl(), 7'b1100100);
    hz.branchD = 1'b0; hz.jumpRegD = 1'b1; hz.writeRegM = 5'd4; #1;
    checkVal("jr_nostall", ctl(), 7'b0000000);
    clearInputs();

    // HI/LO forwarding priority
    hz.hilo_weW = 1'b1; #1;
    checkVal("hilo_W", hz.forwardHiloE, 2'b01);
    hz.hilo_weM = 1'b1; #1;
    checkVal("hilo_M", hz.forwardHiloE, 2'b10);
    clearInputs();

    // full MDU operation: 5 stall cycles, 4 BUSY, 1 DONE
    @(negedge clk);
    hz.mduStartE = 1'b1; hz.hilo_weM = 1'b1; #1;
    checkVal("mdu_issue_ctl", ctl(), 7'b1110010);
    checkVal("mdu_issue_busy", hz.mduBusy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal($sformatf("mdu_busy%0d", i), {hz.mduBusy, hz.mduDone, hz.stallE}, 3'b101);
    end
    tick();
    checkVal("mdu_done", {hz.mduBusy, hz.mduDone, hz.stallE}, 3'b010);
    checkVal("mdu_hilo", hz.forwardHiloE, 2'b11);
    @(negedge clk) hz.mduStartE = 1'b0;
    tick();
    checkVal("mdu_idle", {hz.mduBusy, hz.mduDone}, 2'b00);
    checkVal("mdu_idle_hilo", hz.forwardHiloE, 2'b10);
    clearInputs();

    // exception on the 3rd BUSY cycle
    @(negedge clk) hz.mduStartE = 1'b1;
    tick(); tick(); tick();
    checkVal("exc_busy3", hz.mduBusy, 1);
    @(negedge clk);
    hz.exceptM = 1'b1; #1;
    checkVal("exc_ctl", ctl(), 7'b0001111);
    hz.mduStartE = 1'b0;
    tick();
    checkVal("exc_after", {hz.mduBusy, hz.mduDone, hz.stallF}, 3'b000);
    @(negedge clk) hz.exceptM = 1'b0;
    tick();
    checkVal("exc_stay_idle", {hz.mduBusy, hz.mduDone}, 2'b00);

    // asynchronous reset mid-BUSY, then a full restart
    @(negedge clk) hz.mduStartE = 1'b1;
    tick(); tick();
    checkVal("arst_pre", hz.mduBusy, 1);
    @(negedge clk) hz.mduStartE = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkVal("arst_busy", hz.mduBusy, 0);
    checkVal("arst_ctl", ctl(), 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) hz.mduStartE = 1'b1;
    edges = 0; busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hz.mduBusy) busyCnt++;
      if (hz.mduDone) begin
        edges = i + 1;
        break;
      end
    end
    checkVal("restart_edges", edges, 5);
    checkVal("restart_busy", busyCnt, 4);
    @(negedge clk) hz.mduStartE = 1'b0;

    // stall-cycle counter saturation and exception clear
    @(negedge clk);
    hz.memToRegE = 1'b1; hz.rtE = 5'd8; hz.rsD = 5'd8;
    repeat (20) tick();
    checkVal("perf_sat", hz.stallCycles, PERF_SAT);
    @(negedge clk);
    clearInputs();
    hz.exceptM = 1'b1;
    tick();
    checkVal("perf_clr", hz.stallCycles, 0);
    @(negedge clk) clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
